mdio_phy_responder: RTL and testbench
=====================================

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 The block SHALL have exactly one clock, CLK, and one reset, RST, which is asynchronous and active-high.
REQ-002 The block SHALL have these parameters:
- PHY_ID1, 16'h0141, value read at register 2.
- PHY_ID2, 16'h0CC2, value read at register 3.
- REG0_INIT, 16'h1140, reset value of register 0.
REQ-003 The block SHALL have these ports:
- CLK  in  1  system clock; at least 8x MDC frequency.
- RST  in  1  asynchronous active-high reset.
- MDC  in  1  management clock from the station; asynchronous to CLK.
- MDIO_IN  in  1  management data from the pad.
- MDIO_OUT  out  1  read data driven to the pad.
- MDIO_OE  out  1  pad output enable.
- PHY_ADDR  in  5  own PHY address; quasi-static.
- STATUS_IN  in  16  live value returned for register 1.
- REG_WE  out  1  one-CLK pulse on a committed write.
- REG_ADDR  out  5  register address of the last committed write.
- REG_WD  out  16  data of the last committed write.
- FRAME_ERR  out  1  one-CLK pulse on an aborted frame.

Function
REQ-004 MDC and MDIO_IN SHALL each pass through a 2-flop synchronizer.
REQ-005 Edge detection SHALL run on the synchronized MDC.
REQ-006 MDIO SHALL be sampled only on a detected MDC rising edge.
REQ-007 MDIO_OUT and MDIO_OE SHALL change only on a detected MDC falling edge, within 4 CLK of the pad-level edge.
REQ-008 The states SHALL be IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
REQ-009 A 6-bit bit counter SHALL control the field lengths.
REQ-010 IDLE:
- Count consecutive sampled 1s, saturating at 32; a sampled 0 resets the count.
- A sampled 0 with count = 32 is ST bit 1 and moves to ST.
REQ-011 ST: a sampled 1 moves to OP; a sampled 0 aborts.
REQ-012 OP: bits "10" are a read and "01" are a write; "00" or "11" aborts.
REQ-013 PHYAD: shift in 5 bits MSB first; at the end, a mismatch with PHY_ADDR returns to IDLE silently, with no FRAME_ERR.
REQ-014 REGAD: shift in 5 bits MSB first, then move to TA.
REQ-015 TA for a read:
- First falling edge after the last REGAD bit: MDIO_OE stays 0.
- Second falling edge: MDIO_OE=1 and MDIO_OUT=0.
- The read value SHALL be latched at the end of REGAD.
REQ-016 TA for a write: the sampled bits must be "10"; anything else aborts with no write.
REQ-017 DATA for a read:
- Drive 16 bits MSB first on the next 16 falling edges.
- On the 17th falling edge, MDIO_OE=0 and MDIO_OUT=0, then go to IDLE.
REQ-018 DATA for a write: shift in 16 bits; one CLK after the 16th bit is sampled, assert REG_WE for one cycle and update REG_ADDR, REG_WD and the register file.
REQ-019 Register map:
- 0: writable; bit15 self-clears.
- 1: STATUS_IN, read-only.
- 2: PHY_ID1, read-only.
- 3: PHY_ID2, read-only.
- 4..31: writable 16-bit.
REQ-020 Writes to registers 1-3 SHALL pulse REG_WE but leave the stored contents unchanged.
REQ-021 A write to register 0 with bit15=1 SHALL do all of the following:
- Restore register 0 to REG0_INIT.
- Clear registers 4..31 to 0.
- Read back with bit15=0 from then on.
REQ-022 An abort SHALL pulse FRAME_ERR for one CLK, force MDIO_OE=0, clear the preamble count and return to IDLE.
REQ-023 A preamble (32 ones) received mid-frame SHALL NOT resynchronize the frame; only an abort or frame end returns to IDLE.
REQ-024 Back-to-back frames with no idle bits SHALL each be accepted, provided each carries a full preamble.

Reset
REQ-025 While RST=1, all of the following SHALL hold:
- State = IDLE; preamble count and bit counter = 0.
- MDIO_OE=0, MDIO_OUT=0.
- REG_WE=0, FRAME_ERR=0, REG_ADDR=0, REG_WD=0.
- Register 0 = REG0_INIT; registers 4..31 = 0; synchronizer flops = 0.
REQ-026 An RST assertion mid-frame SHALL release MDIO_OE within 1 CLK (asynchronously).
REQ-027 After RST is released, the block SHALL require a fresh 32-bit preamble.

Configuration
REQ-028 With macro MDIO_BCAST_EN defined, PHY address 0 SHALL be accepted for writes in addition to PHY_ADDR, and broadcast reads SHALL be ignored with MDIO_OE held at 0.
REQ-029 Without MDIO_BCAST_EN, only PHY_ADDR SHALL match; when PHY_ADDR=0, address 0 SHALL behave as a normal address for both reads and writes.

Verification
REQ-030 PHY_ADDR=7, 32 ones, then a write frame to PHY 7, reg 4, data 16'hA5C3 -> one REG_WE pulse with REG_ADDR=4 and REG_WD=16'hA5C3; a subsequent read of reg 4 returns 16'hA5C3.
REQ-031 Read of reg 1 with STATUS_IN=16'h796D -> MDIO_OE high for exactly 17 MDC periods, driving TA bit 0 then 16'h796D; reads of regs 2 and 3 return 16'h0141 and 16'h0CC2.
REQ-032 Read frame to PHY 5 while PHY_ADDR=7 -> MDIO_OE stays 0, no FRAME_ERR; the next valid frame is accepted.
REQ-033 Preamble of only 31 ones, then ST -> frame ignored; OP bits "11" after a valid preamble -> one FRAME_ERR pulse with no REG_WE.
REQ-034 Write 16'h1234 to reg 9, then 16'h8000 to reg 0 -> reg 0 reads 16'h1140 and reg 9 reads 16'h0000.
REQ-035 RST asserted during read DATA bit 8 -> MDIO_OE=0 within 1 CLK; no response until a full preamble follows reset release. With MDIO_BCAST_EN defined, a write to PHY 0 reg 5 -> REG_WE pulses.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
//
// Clause-22 MDIO slave (PHY side). MDC and MDIO_IN are oversampled by the
// system clock CLK (at least 8x MDC), synchronised, and decoded into read and
// write frames addressed to this PHY. A small register file answers reads and
// reports committed writes on a one-cycle strobe.
//
// Optional feature: define MDIO_BCAST_EN to accept writes addressed to PHY 0
// as a broadcast (in addition to PHY_ADDR); broadcast reads are ignored.
// Without the macro only PHY_ADDR matches, and 0 is an ordinary address.
//
// Ports
//   CLK        system clock
//   RST        asynchronous active-high reset
//   MDC        management clock from the station (asynchronous to CLK)
//   MDIO_IN    management data from the pad
//   MDIO_OUT   read data to the pad
//   MDIO_OE    pad output enable
//   PHY_ADDR   own PHY address (quasi-static)
//   STATUS_IN  live value returned for register 1
//   REG_WE     one-CLK pulse on a committed write
//   REG_ADDR   register address of the last committed write
//   REG_WD     data of the last committed write
//   FRAME_ERR  one-CLK pulse on an aborted frame
//
// Handshake: there is no valid/ready flow control. REG_WE is a single-cycle
// qualifier: REG_ADDR/REG_WD are valid in (and held after) the cycle REG_WE=1.
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
   parameter logic [15:0] PHY_ID1   = 16'h0141,
   parameter logic [15:0] PHY_ID2   = 16'h0CC2,
   parameter logic [15:0] REG0_INIT = 16'h1140
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MDC,
   input  logic        MDIO_IN,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   input  logic [4:0]  PHY_ADDR,
   input  logic [15:0] STATUS_IN,
   output logic        REG_WE,
   output logic [4:0]  REG_ADDR,
   output logic [15:0] REG_WD,
   output logic        FRAME_ERR
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ST    = 3'd1,
      S_OP    = 3'd2,
      S_PHYAD = 3'd3,
      S_REGAD = 3'd4,
      S_TA    = 3'd5,
      S_DATA  = 3'd6
   } state_t;

   state_t      state_q, state_d;

   logic        mdc_s1_q, mdc_s2_q, mdc_prev_q;
   logic        mdio_s1_q, mdio_s2_q;

   logic [5:0]  pre_cnt_q, pre_cnt_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic        is_read_q, is_read_d;
   logic [4:0]  regad_q, regad_d;
   logic [15:0] shift_q, shift_d;
   logic        oe_q, oe_d;
   logic        out_q, out_d;
   logic        we_q, we_d;
   logic        ferr_q, ferr_d;
   logic [4:0]  reg_addr_q, reg_addr_d;
   logic [15:0] reg_wd_q, reg_wd_d;
   logic [15:0] rf_q [32];
   logic [15:0] rf_d [32];

   logic        rise, fall, bit_in;
   logic        abort;
   logic        addr_ok;
   logic [4:0]  field_new;
   logic [15:0] rd_value;
   logic [15:0] wdata;

   // Edges are detected on the synchronised MDC; MDIO_IN passes through an
   // identical synchroniser so the sampled bit stays aligned with the edge.
   assign rise   = mdc_s2_q & ~mdc_prev_q;
   assign fall   = ~mdc_s2_q & mdc_prev_q;
   assign bit_in = mdio_s2_q;

   // 5-bit address field including the bit arriving on this rising edge.
   assign field_new = {shift_q[3:0], bit_in};
   assign wdata     = {shift_q[14:0], bit_in};

`ifdef MDIO_BCAST_EN
   assign addr_ok = is_read_q ? ((field_new == PHY_ADDR) && (field_new != 5'd0))
                              : ((field_new == PHY_ADDR) || (field_new == 5'd0));
`else
   assign addr_ok = (field_new == PHY_ADDR);
`endif

   // Read value for the register address completing on this edge.
   always_comb begin
      rd_value = rf_q[field_new];
      case (field_new)
         5'd0:    rd_value = rf_q[0] & 16'h7FFF;  // bit15 always reads 0
         5'd1:    rd_value = STATUS_IN;
         5'd2:    rd_value = PHY_ID1;
         5'd3:    rd_value = PHY_ID2;
         default: rd_value = rf_q[field_new];
      endcase
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mdc_s1_q   <= 1'b0;
         mdc_s2_q   <= 1'b0;
         mdc_prev_q <= 1'b0;
         mdio_s1_q  <= 1'b0;
         mdio_s2_q  <= 1'b0;
         state_q    <= S_IDLE;
         pre_cnt_q  <= 6'd0;
         bit_cnt_q  <= 6'd0;
         is_read_q  <= 1'b0;
         regad_q    <= 5'd0;
         shift_q    <= 16'h0000;
         oe_q       <= 1'b0;
         out_q      <= 1'b0;
         we_q       <= 1'b0;
         ferr_q     <= 1'b0;
         reg_addr_q <= 5'd0;
         reg_wd_q   <= 16'h0000;
         for (int i = 0; i < 32; i++) rf_q[i] <= 16'h0000;
         rf_q[0]    <= REG0_INIT;
      end else begin
         mdc_s1_q   <= MDC;
         mdc_s2_q   <= mdc_s1_q;
         mdc_prev_q <= mdc_s2_q;
         mdio_s1_q  <= MDIO_IN;
         mdio_s2_q  <= mdio_s1_q;
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         is_read_q  <= is_read_d;
         regad_q    <= regad_d;
         shift_q    <= shift_d;
         oe_q       <= oe_d;
         out_q      <= out_d;
         we_q       <= we_d;
         ferr_q     <= ferr_d;
         reg_addr_q <= reg_addr_d;
         reg_wd_q   <= reg_wd_d;
         rf_q       <= rf_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         S_IDLE:  if (rise && !bit_in && (pre_cnt_q == 6'd32)) state_d = S_ST;
         S_ST:    if (rise) begin
                     if (bit_in) state_d = S_OP;
                     else        abort   = 1'b1;
                  end
         // "10" read, "01" write: valid exactly when the two bits differ.
         S_OP:    if (rise && (bit_cnt_q == 6'd1)) begin
                     if (shift_q[0] != bit_in) state_d = S_PHYAD;
                     else                      abort   = 1'b1;
                  end
         // Foreign address: drop back silently, this frame is not ours.
         S_PHYAD: if (rise && (bit_cnt_q == 6'd4)) state_d = addr_ok ? S_REGAD : S_IDLE;
         S_REGAD: if (rise && (bit_cnt_q == 6'd4)) state_d = S_TA;
         S_TA:    if (is_read_q) begin
                     if (fall && (bit_cnt_q == 6'd1)) state_d = S_DATA;
                  end else if (rise && (bit_cnt_q == 6'd1)) begin
                     if ({shift_q[0], bit_in} == 2'b10) state_d = S_DATA;
                     else                               abort   = 1'b1;
                  end
         S_DATA:  if (is_read_q) begin
                     if (fall && (bit_cnt_q == 6'd16)) state_d = S_IDLE;
                  end else if (rise && (bit_cnt_q == 6'd15)) begin
                     state_d = S_IDLE;
                  end
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // ------------------------------------------------------- datapath / outputs
   always_comb begin
      pre_cnt_d  = pre_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      is_read_d  = is_read_q;
      regad_d    = regad_q;
      shift_d    = shift_q;
      oe_d       = oe_q;
      out_d      = out_q;
      we_d       = 1'b0;
      ferr_d     = 1'b0;
      reg_addr_d = reg_addr_q;
      reg_wd_d   = reg_wd_q;
      rf_d       = rf_q;

      case (state_q)
         S_IDLE: if (rise) begin
            if (bit_in) pre_cnt_d = (pre_cnt_q == 6'd32) ? 6'd32 : pre_cnt_q + 6'd1;
            else        pre_cnt_d = 6'd0;
         end
         S_OP, S_PHYAD: if (rise) begin
            shift_d   = wdata;
            bit_cnt_d = bit_cnt_q + 6'd1;
            if ((state_q == S_OP) && (bit_cnt_q == 6'd1)) is_read_d = shift_q[0];
         end
         S_REGAD: if (rise) begin
            shift_d   = wdata;
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd4) begin
               regad_d = field_new;
               // Snapshot the read value now so it is stable for the data phase.
               if (is_read_q) shift_d = rd_value;
            end
         end
         S_TA: if (is_read_q) begin
            if (fall) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               // Second turnaround bit: take the bus and drive 0.
               if (bit_cnt_q == 6'd1) begin
                  oe_d  = 1'b1;
                  out_d = 1'b0;
               end
            end
         end else if (rise) begin
            shift_d   = wdata;
            bit_cnt_d = bit_cnt_q + 6'd1;
         end
         S_DATA: if (is_read_q) begin
            if (fall) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q < 6'd16) begin
                  out_d   = shift_q[15];
                  shift_d = {shift_q[14:0], 1'b0};
               end else begin
                  oe_d  = 1'b0;
                  out_d = 1'b0;
               end
            end
         end else if (rise) begin
            shift_d   = wdata;
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd15) begin
               we_d       = 1'b1;
               reg_addr_d = regad_q;
               reg_wd_d   = wdata;
               case (regad_q)
                  5'd0: begin
                     if (wdata[15]) begin
                        // Soft reset: restore reg 0 and clear the scratch space.
                        rf_d[0] = REG0_INIT;
                        for (int i = 4; i < 32; i++) rf_d[i] = 16'h0000;
                     end else begin
                        rf_d[0] = wdata;
                     end
                  end
                  5'd1, 5'd2, 5'd3: ;  // read-only: strobe only
                  default: rf_d[regad_q] = wdata;
               endcase
            end
         end
         default: ;
      endcase

      if (state_d != state_q) bit_cnt_d = 6'd0;

      if (abort) begin
         ferr_d    = 1'b1;
         oe_d      = 1'b0;
         out_d     = 1'b0;
         pre_cnt_d = 6'd0;
      end
   end

   assign MDIO_OUT  = out_q;
   assign MDIO_OE   = oe_q;
   assign REG_WE    = we_q;
   assign REG_ADDR  = reg_addr_q;
   assign REG_WD    = reg_wd_q;
   assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_responder
//
// Station-side bench for mdio_phy_responder. Frames are driven bit by bit on
// MDC/MDIO_IN; the expected outcome of each frame (write strobe, frame error,
// read data, output-enable duration) comes from a frame-level model of the
// register map kept here.
// -----------------------------------------------------------------------------
module tb_mdio_phy_responder;

   localparam int HALF = 40;  // MDC half period in ns (CLK period 10 ns)

   logic        CLK = 1'b0;
   logic        RST;
   logic        MDC;
   logic        MDIO_IN;
   logic        MDIO_OUT;
   logic        MDIO_OE;
   logic [4:0]  PHY_ADDR;
   logic [15:0] STATUS_IN;
   logic        REG_WE;
   logic [4:0]  REG_ADDR;
   logic [15:0] REG_WD;
   logic        FRAME_ERR;

   int n_tests = 0;
   int n_fail  = 0;

   int          we_cnt   = 0;
   int          ferr_cnt = 0;
   logic [4:0]  we_addr  = 5'd0;
   logic [15:0] we_data  = 16'h0000;

   logic [15:0] exp_q[$];
   logic [15:0] model_rf [32];

   mdio_phy_responder dut (
      .CLK       (CLK),
      .RST       (RST),
      .MDC       (MDC),
      .MDIO_IN   (MDIO_IN),
      .MDIO_OUT  (MDIO_OUT),
      .MDIO_OE   (MDIO_OE),
      .PHY_ADDR  (PHY_ADDR),
      .STATUS_IN (STATUS_IN),
      .REG_WE    (REG_WE),
      .REG_ADDR  (REG_ADDR),
      .REG_WD    (REG_WD),
      .FRAME_ERR (FRAME_ERR)
   );

   // ------------------------------------------------------------ clock/reset
   always #5 CLK = ~CLK;

   // Strobe monitor: counts every CLK cycle the strobes are high, so a pulse
   // wider than one cycle shows up as an extra count.
   always @(posedge CLK) begin
      if (REG_WE) begin
         we_cnt  = we_cnt + 1;
         we_addr = REG_ADDR;
         we_data = REG_WD;
      end
      if (FRAME_ERR) ferr_cnt = ferr_cnt + 1;
   end

   // ---------------------------------------------------------------- checker
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------ model
   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = 16'h0000;
      model_rf[0] = 16'h1140;
   endtask

   function automatic logic [15:0] model_read(input logic [4:0] rg);
      case (rg)
         5'd0:    return model_rf[0] & 16'h7FFF;
         5'd1:    return STATUS_IN;
         5'd2:    return 16'h0141;
         5'd3:    return 16'h0CC2;
         default: return model_rf[rg];
      endcase
   endfunction

   task automatic model_write(input logic [4:0] rg, input logic [15:0] wd);
      if (rg == 5'd0) begin
         if (wd[15]) begin
            model_rf[0] = 16'h1140;
            for (int i = 4; i < 32; i++) model_rf[i] = 16'h0000;
         end else begin
            model_rf[0] = wd;
         end
      end else if (rg > 5'd3) begin
         model_rf[rg] = wd;
      end
   endtask

   // ---------------------------------------------------------------- drivers
   // One MDC period: station drives on the falling edge, the PHY output is
   // sampled just before the following rising edge.
   task automatic mdc_bit(input logic b, output logic o, output logic oe);
      MDC     = 1'b0;
      MDIO_IN = b;
      #(HALF - 3);
      o  = MDIO_OUT;
      oe = MDIO_OE;
      #3;
      MDC = 1'b1;
      #HALF;
   endtask

   task automatic send_header(input int pre_len, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] rg,
                              inout int oe_cnt);
      logic o, oe;
      for (int i = 0; i < pre_len; i++) begin mdc_bit(1'b1, o, oe); oe_cnt += int'(oe); end
      mdc_bit(1'b0, o, oe); oe_cnt += int'(oe);
      mdc_bit(1'b1, o, oe); oe_cnt += int'(oe);
      for (int i = 1; i >= 0; i--) begin mdc_bit(op[i], o, oe);  oe_cnt += int'(oe); end
      for (int i = 4; i >= 0; i--) begin mdc_bit(phy[i], o, oe); oe_cnt += int'(oe); end
      for (int i = 4; i >= 0; i--) begin mdc_bit(rg[i], o, oe);  oe_cnt += int'(oe); end
   endtask

   // Full frame followed by one idle 0 bit (also checks the bus is released).
   task automatic run_frame(input int pre_len, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] rg,
                            input logic [1:0] ta, input logic [15:0] wd,
                            output logic [15:0] rd, output logic ta_o,
                            output int oe_cnt);
      logic o, oe;
      rd = 16'h0000;
      ta_o = 1'bx;
      oe_cnt = 0;
      send_header(pre_len, op, phy, rg, oe_cnt);
      if (op == 2'b10) begin
         for (int i = 0; i < 18; i++) begin
            mdc_bit(1'b1, o, oe);
            oe_cnt += int'(oe);
            if (i == 1) ta_o = o;
            if (i >= 2) rd = {rd[14:0], o};
         end
      end else begin
         for (int i = 1; i >= 0; i--)  begin mdc_bit(ta[i], o, oe); oe_cnt += int'(oe); end
         for (int i = 15; i >= 0; i--) begin mdc_bit(wd[i], o, oe); oe_cnt += int'(oe); end
      end
      mdc_bit(1'b0, o, oe);
      oe_cnt += int'(oe);
   endtask

   // Predict the outcome of a frame, run it, and score it.
   task automatic do_frame(input int pre_len, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [1:0] ta, input logic [15:0] wd);
      int          we0, fe0, oe_cnt;
      logic        pre_ok, op_ok, addr_ok, exp_abort, exp_rd, exp_wr, ta_o;
      logic [15:0] rd, exp;
      we0    = we_cnt;
      fe0    = ferr_cnt;
      pre_ok = (pre_len >= 32);
      op_ok  = (op == 2'b10) || (op == 2'b01);
`ifdef MDIO_BCAST_EN
      addr_ok = (op == 2'b10) ? ((phy == PHY_ADDR) && (phy != 5'd0))
                              : ((phy == PHY_ADDR) || (phy == 5'd0));
`else
      addr_ok = (phy == PHY_ADDR);
`endif
      exp_abort = pre_ok && (!op_ok || ((op == 2'b01) && addr_ok && (ta != 2'b10)));
      exp_rd    = pre_ok && (op == 2'b10) && addr_ok;
      exp_wr    = pre_ok && (op == 2'b01) && addr_ok && (ta == 2'b10);
      if (exp_rd) exp_q.push_back(model_read(rg));
      run_frame(pre_len, op, phy, rg, ta, wd, rd, ta_o, oe_cnt);
      check("we_pulses",  32'(we_cnt - we0),   32'(exp_wr));
      check("ferr_pulses", 32'(ferr_cnt - fe0), 32'(exp_abort));
      check("oe_cycles",  32'(oe_cnt),         exp_rd ? 32'd17 : 32'd0);
      if (exp_rd) begin
         exp = exp_q.pop_front();
         check("rd_data", 32'(rd), 32'(exp));
         check("ta_bit",  32'(ta_o), 32'd0);
      end
      if (exp_wr) begin
         check("we_addr", 32'(we_addr), 32'(rg));
         check("we_data", 32'(we_data), 32'(wd));
         model_write(rg, wd);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_oe"},   32'(MDIO_OE),   32'd0);
      check({tag, "_out"},  32'(MDIO_OUT),  32'd0);
      check({tag, "_we"},   32'(REG_WE),    32'd0);
      check({tag, "_ferr"}, 32'(FRAME_ERR), 32'd0);
      check({tag, "_addr"}, 32'(REG_ADDR),  32'd0);
      check({tag, "_wd"},   32'(REG_WD),    32'd0);
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      logic o, oe;
      logic [1:0]  op, ta;
      logic [4:0]  phy, rg;
      logic [15:0] wd;
      int          pre, sel;

      RST       = 1'b1;
      MDC       = 1'b0;
      MDIO_IN   = 1'b0;
      PHY_ADDR  = 5'd7;
      STATUS_IN = 16'h0000;
      model_reset();
      repeat (3) @(posedge CLK);
      #2;
      check_reset_outputs("reset");
      RST = 1'b0;
      mdc_bit(1'b0, o, oe);

      // Write then read back.
      do_frame(32, 2'b01, 5'd7, 5'd4, 2'b10, 16'hA5C3);
      do_frame(32, 2'b10, 5'd7, 5'd4, 2'b10, 16'h0000);

      // Status and ID registers.
      STATUS_IN = 16'h796D;
      do_frame(32, 2'b10, 5'd7, 5'd1, 2'b10, 16'h0000);
      do_frame(33, 2'b10, 5'd7, 5'd2, 2'b10, 16'h0000);
      do_frame(32, 2'b10, 5'd7, 5'd3, 2'b10, 16'h0000);

      // Foreign PHY, then a valid frame.
      do_frame(32, 2'b10, 5'd5, 5'd4, 2'b10, 16'h0000);
      do_frame(32, 2'b10, 5'd7, 5'd4, 2'b10, 16'h0000);

      // Short preamble, bad opcode, bad write turnaround.
      do_frame(31, 2'b01, 5'd7, 5'd6, 2'b10, 16'h5555);
      do_frame(32, 2'b11, 5'd7, 5'd6, 2'b10, 16'h5555);
      do_frame(32, 2'b01, 5'd7, 5'd6, 2'b11, 16'h5555);

      // Soft reset through register 0 bit 15.
      do_frame(32, 2'b01, 5'd7, 5'd9, 2'b10, 16'h1234);
      do_frame(32, 2'b01, 5'd7, 5'd0, 2'b10, 16'h8000);
      do_frame(32, 2'b10, 5'd7, 5'd0, 2'b10, 16'h0000);
      do_frame(32, 2'b10, 5'd7, 5'd9, 2'b10, 16'h0000);

      // Reset asserted in the middle of read data bit 8.
      do_frame(32, 2'b01, 5'd7, 5'd12, 2'b10, 16'hFFFF);
      begin
         int dummy = 0;
         send_header(32, 2'b10, 5'd7, 5'd12, dummy);
      end
      for (int i = 0; i < 9; i++) mdc_bit(1'b1, o, oe);  // TA1, TA2, D1..D7
      MDC     = 1'b0;
      MDIO_IN = 1'b1;
      #(HALF - 3);
      check("oe_before_rst", 32'(MDIO_OE), 32'd1);
      RST = 1'b1;
      #2;
      check("oe_async_release", 32'(MDIO_OE), 32'd0);
      #1;
      MDC = 1'b1;
      #HALF;
      for (int i = 0; i < 3; i++) mdc_bit(1'b1, o, oe);
      check_reset_outputs("midrst");
      model_reset();
      RST = 1'b0;
      mdc_bit(1'b0, o, oe);
      do_frame(31, 2'b10, 5'd7, 5'd2, 2'b10, 16'h0000);
      do_frame(32, 2'b10, 5'd7, 5'd2, 2'b10, 16'h0000);
      do_frame(32, 2'b10, 5'd7, 5'd12, 2'b10, 16'h0000);

      // Address 0: broadcast (when enabled) with PHY_ADDR=7, then own address 0.
      do_frame(32, 2'b01, 5'd0, 5'd5, 2'b10, 16'h0BAD);
      do_frame(32, 2'b10, 5'd0, 5'd5, 2'b10, 16'h0000);
      PHY_ADDR = 5'd0;
      do_frame(32, 2'b01, 5'd0, 5'd10, 2'b10, 16'hC0DE);
      do_frame(32, 2'b10, 5'd0, 5'd10, 2'b10, 16'h0000);
      PHY_ADDR = 5'd7;
      do_frame(32, 2'b10, 5'd7, 5'd10, 2'b10, 16'h0000);

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         op  = (sel < 4) ? 2'b10 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b11 : 2'b00;
         phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY_ADDR;
         rg  = 5'($urandom_range(0, 31));
         ta  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         wd  = 16'($urandom);
         pre = ($urandom_range(0, 7) == 0) ? 31 : 32 + int'($urandom_range(0, 2));
         STATUS_IN = 16'($urandom);
         do_frame(pre, op, phy, rg, ta, wd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
